inst_fetch_buffer: RTL and testbench

- Consumer end of the program counter: takes the PC module's pc and pc_4, fetches instruction words from instruction memory, and queues them for decode.
- Issues in-order requests over a req/gnt + rvalid memory interface with variable latency.
- Buffers returned words with their addresses in a small FIFO and presents them to decode with a valid/ready handshake.
- Drives pc_advance back to the PC so the PC only steps when a fetch is accepted; on redirect, discards queued and in-flight fetches.

---
 rtl/inst_fetch_buffer_pkg.sv | 28 ++
 rtl/inst_fetch_buffer_sync_fifo.sv | 72 +++++++
 rtl/inst_fetch_buffer.sv | 157 +++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// rtl/inst_fetch_buffer_pkg.sv - shared ranges, fetch state and FIFO entry type
//
// Purpose: common definitions for the instruction fetch buffer slice.
//   `REG_RANGE  : address/register bit range (31:0)
//   `INST_RANGE : instruction word bit range (31:0)
//   fetch_state_t : RUN (issuing) / DRAIN (discarding stale responses)
//   fetch_entry_t : one buffered instruction with the address it came from

`ifndef REG_RANGE
`define REG_RANGE 31:0
`endif
`ifndef INST_RANGE
`define INST_RANGE 31:0
`endif

package inst_fetch_buffer_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [`INST_RANGE] inst;
      logic [`REG_RANGE]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_sync_fifo.sv
// rtl/inst_fetch_buffer_sync_fifo.sv - single-clock FIFO with clear and occupancy count
//
// Purpose: power-of-two deep FIFO used for both the pending-address queue
// and the instruction queue of the fetch buffer.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clear           : drop all entries this edge (wins over push/pop)
//   push, push_data : write one entry
//   pop, pop_data   : pop_data is the head, pop removes it
//   count           : entries held (0..DEPTH)
//   full, empty     : occupancy flags

`ifndef REG_RANGE
`define REG_RANGE 31:0
`endif

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_COUNT);
   assign do_pop   = pop & ~empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && full && !pop && !clear));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(pop && empty && !clear));

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - in-order instruction fetch queue between PC and decode
//
// Purpose: issues fetches at pc over a req/gnt + rvalid memory port, pairs
// returned words with their addresses and queues them for decode.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   pc, pc_4                    : current fetch address and pc+4 from the PC
//   pc_advance                  : PC steps this edge (a fetch was accepted)
//   flush                       : PC redirect this edge; drop everything older
//   imem_req/addr/gnt           : request side of instruction memory
//   imem_rvalid/rdata           : in-order responses, at least one cycle after gnt
//   inst_valid/ready            : decode handshake for the queue head
//   inst, inst_pc, inst_pc_4    : head instruction, its address and address+4

`ifndef REG_RANGE
`define REG_RANGE 31:0
`endif
`ifndef INST_RANGE
`define INST_RANGE 31:0
`endif

module inst_fetch_buffer
   import inst_fetch_buffer_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [`REG_RANGE] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [`REG_RANGE]   pc,
   input  logic [`REG_RANGE]   pc_4,
   output logic                pc_advance,
   input  logic                flush,
   output logic                imem_req,
   output logic [`REG_RANGE]   imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [`INST_RANGE]  imem_rdata,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [`INST_RANGE]  inst,
   output logic [`REG_RANGE]   inst_pc,
   output logic [`REG_RANGE]   inst_pc_4
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   fetch_state_t      state;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occupancy;
   logic [CW-1:0]     outstanding;
   logic              accept;
   logic              resp_take;
   logic              deq;
   logic              pend_full;
   logic              pend_empty;
   logic              fifo_full;
   logic              fifo_empty;
   logic [`REG_RANGE] pend_head;
   fetch_entry_t      fifo_in;
   fetch_entry_t      fifo_head;

   // Every outstanding request owns a pending-address slot, so the pending
   // queue occupancy is the in-flight count. Only registered counts feed the
   // request, keeping rvalid/inst_ready off the imem_req path.
   assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
   assign imem_req   = !reset && !flush && (state == RUN) && (occupancy < DEPTH_W);
   assign accept     = imem_req & imem_gnt;
   assign pc_advance = accept;
   assign imem_addr  = pc;

   // Responses are only kept in RUN outside a flush; in DRAIN every one is stale.
   assign resp_take  = imem_rvalid && (state == RUN) && !flush;
   assign deq        = inst_valid && inst_ready && !flush;
   assign fifo_in    = '{inst: imem_rdata, pc: pend_head};

   // Responses still owed by memory after this edge.
   assign outstanding = inflight + CW'(accept) - CW'(imem_rvalid);

   sync_fifo #(.WIDTH($bits(pend_head)), .DEPTH(DEPTH)) u_pend_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (accept),
      .push_data (pc),
      .pop       (resp_take),
      .pop_data  (pend_head),
      .count     (inflight),
      .full      (pend_full),
      .empty     (pend_empty)
   );

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (resp_take),
      .push_data (fifo_in),
      .pop       (deq),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         drop  <= '0;
      end else begin
         case (state)
            RUN: begin
               if (flush && (outstanding != '0)) begin
                  state <= DRAIN;
                  drop  <= outstanding;
               end
            end
            DRAIN: begin
               // A redirect here adds nothing to drop: no request was issued.
               if (imem_rvalid) begin
                  drop <= drop - CW'(1);
                  if (drop == CW'(1)) begin
                     state <= RUN;
                  end
               end
            end
            default: begin
               state <= RUN;
               drop  <= '0;
            end
         endcase
      end
   end

   // Outputs read as zero while the queue is empty.
   assign inst_valid = !fifo_empty;
   assign inst       = inst_valid ? fifo_head.inst : '0;
   assign inst_pc    = inst_valid ? fifo_head.pc : '0;
   assign inst_pc_4  = inst_valid ? (fifo_head.pc + 32'd4) : '0;

   a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
      !(imem_rvalid && (inflight == '0) && (drop == '0)));
   a_pend_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(accept && pend_full));
   a_pend_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(resp_take && pend_empty));
   a_inst_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(resp_take && fifo_full && !deq));
   a_pc_4_consistent: assert property (@(posedge clk) disable iff (reset)
      pc_4 == pc + 32'd4);
   a_pc_reset_value: assert property (@(posedge clk)
      $past(reset) |-> pc == RESET_PC);

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - randomized self-checking bench for inst_fetch_buffer

module tb_inst_fetch_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic        inst_ready = 1'b0;
   logic        pc_advance, imem_req, inst_valid;
   logic [31:0] pc = 32'h0;
   logic [31:0] pc_4;
   logic [31:0] imem_addr, inst, inst_pc, inst_pc_4;
   logic [31:0] imem_rdata = 32'h0;

   always #5 clk = ~clk;
   assign pc_4 = pc + 32'd4;

   inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .pc(pc), .pc_4(pc_4), .pc_advance(pc_advance),
      .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_pc_4(inst_pc_4)
   );

   typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;

   mreq_t       mem_q[$];
   exp_t        exp_q[$];
   logic [31:0] seen_pc[$];
   int          checks = 0, failures = 0, cyc = 0, epoch = 0;
   int          gnt_pct = 100, rv_pct = 100, rdy_pct = 100, flush_pct = 0;
   int          lat_min = 1, lat_max = 1;
   bit          rand_jump = 0;
   logic [31:0] jump_addr = 32'h0;
   logic        last_req;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // One clock: drive inputs at negedge, check against the model, then
   // advance the model just after the rising edge.
   task automatic step(input bit rst, input bit force_flush);
      bit          fl, rv, accepted, popped;
      int          cur, stale;
      mreq_t       r;
      logic [31:0] e_pc4;
      cur = 0;
      stale = 0;
      @(negedge clk);
      if (rand_jump) jump_addr = $urandom() & 32'hFFFF_FFFC;
      reset = rst;
      fl = !rst && (force_flush || ($urandom_range(99) < flush_pct));
      flush = fl;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      inst_ready = ($urandom_range(99) < rdy_pct);
      rv = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rv_pct);
      imem_rvalid = rv;
      imem_rdata = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
      foreach (mem_q[i]) begin
         if (mem_q[i].epoch == epoch) cur++;
         else stale++;
      end
      #1;
      chk("imem_req", imem_req, !rst && !fl && (stale == 0) && ((exp_q.size() + cur) < DEPTH));
      chk("pc_advance", pc_advance, imem_req && imem_gnt);
      chk("imem_addr", imem_addr, pc);
      chk("inst_valid", inst_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         e_pc4 = exp_q[0].addr + 32'd4;
         chk("inst", inst, exp_q[0].data);
         chk("inst_pc", inst_pc, exp_q[0].addr);
         chk("inst_pc_4", inst_pc_4, e_pc4);
      end else begin
         chk("inst_idle", inst, 32'h0);
         chk("inst_pc_idle", inst_pc, 32'h0);
         chk("inst_pc_4_idle", inst_pc_4, 32'h0);
      end
      last_req = imem_req;
      accepted = imem_req && imem_gnt;
      popped = inst_valid && inst_ready;
      @(posedge clk);
      #1;
      if (rst) begin
         mem_q.delete();
         exp_q.delete();
         epoch++;
         pc = 32'h0;
      end else begin
         if (fl) begin
            exp_q.delete();
            epoch++;
         end else if (popped && exp_q.size() > 0) begin
            seen_pc.push_back(exp_q[0].addr);
            void'(exp_q.pop_front());
         end
         if (rv) begin
            r = mem_q.pop_front();
            if (!fl && r.epoch == epoch) exp_q.push_back('{addr: r.addr, data: mem_word(r.addr)});
         end
         if (accepted)
            mem_q.push_back('{addr: pc, epoch: epoch, due: cyc + int'($urandom_range(lat_max, lat_min))});
         if (fl) pc = jump_addr;
         else if (accepted) pc = pc + 32'd4;
      end
      cyc++;
   endtask

   task automatic check_seen(input string tag, input logic [31:0] first, input int n);
      logic [31:0] e, g;
      for (int i = 0; i < n; i++) begin
         e = first + 32'(4 * i);
         g = (seen_pc.size() > i) ? seen_pc[i] : ~e;
         chk(tag, g, e);
      end
   endtask

   task automatic setup(input int g, input int rdy, input int lmin, input int lmax);
      gnt_pct = g; rdy_pct = rdy; lat_min = lmin; lat_max = lmax;
      rv_pct = 100; flush_pct = 0; rand_jump = 0;
      step(1, 0);
      seen_pc.delete();
   endtask

   initial begin
      step(1, 0);
      step(1, 0);

      // 1-cycle memory, decode always ready
      setup(100, 100, 1, 1);
      repeat (12) step(0, 0);
      check_seen("seq_1cyc", 32'h0, 4);

      // Backpressure: queue fills, requests stop, then drains in order
      setup(100, 0, 1, 1);
      repeat (10) step(0, 0);
      chk("bp_req_low", imem_req, 1'b0);
      chk("bp_valid_held", inst_valid, 1'b1);
      rdy_pct = 100;
      repeat (10) step(0, 0);
      check_seen("seq_bp", 32'h0, 6);

      // 3-cycle responses: inflight saturates, order kept
      setup(100, 100, 3, 3);
      repeat (16) step(0, 0);
      check_seen("seq_lat3", 32'h0, 6);

      // Flush with two responses outstanding, redirect to 0000FFFF
      setup(100, 100, 3, 3);
      jump_addr = 32'h0000_FFFF;
      step(0, 0);
      step(0, 0);
      step(0, 1);
      repeat (12) step(0, 0);
      check_seen("seq_redirect", 32'h0000_FFFF, 3);

      // Flush on a cycle carrying a response with decode ready
      setup(100, 100, 2, 2);
      jump_addr = 32'h0000_0100;
      repeat (4) step(0, 0);
      seen_pc.delete();
      step(0, 1);
      repeat (12) step(0, 0);
      check_seen("seq_flush_rv", 32'h0000_0100, 3);

      // Address wrap
      setup(100, 100, 1, 1);
      jump_addr = 32'hFFFF_FFFC;
      step(0, 1);
      repeat (10) step(0, 0);
      check_seen("seq_wrap", 32'hFFFF_FFFC, 3);

      // Reset in the middle of DRAIN
      setup(100, 100, 5, 5);
      jump_addr = 32'h0000_0400;
      repeat (3) step(0, 0);
      step(0, 1);
      step(0, 0);
      step(1, 0);
      step(0, 0);
      chk("post_reset_run", last_req, 1'b1);
      chk("post_reset_valid", inst_valid, 1'b0);

      // Randomized traffic with redirects
      setup(70, 60, 1, 4);
      rv_pct = 70;
      flush_pct = 5;
      rand_jump = 1;
      repeat (3000) step(0, 0);
      rand_jump = 0;
      flush_pct = 0;
      rv_pct = 100;
      repeat (20) step(0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
